// File: rtl/ad5318_frame_rx.sv
// AD5318 serial-link receiver: oversampled SCLK/DIN/SYNC_b deserialiser with a tvalid/tready word stream.
// Define AD5318_RX_REGFILE_EN to add the input/DAC register file driven by LDAC_b.
`timescale 1ns/1ps
module ad5318_frame_rx #(
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clkin,
  input  logic        rst,
  input  logic        SCLK,
  input  logic        DIN,
  input  logic        SYNC_b,
  input  logic        LDAC_b,
  output logic [15:0] tdata,
  output logic [2:0]  tuser,
  output logic        tctrl,
  output logic        tvalid,
  input  logic        tready,
  output logic        frame_err,
  output logic        overrun
`ifdef AD5318_RX_REGFILE_EN
  ,
  output logic [79:0] dac_value
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, din_sync, syncb_sync;
  logic                   sclk_d, syncb_d;
  logic                   sclk_s, din_s, syncb_s;
  logic                   sclk_fall, syncb_rise, commit;
  logic [15:0]            shreg, shift_next;
  logic [4:0]             bit_cnt;
  logic                   primed, armed;

  always_ff @(posedge clkin) begin
    if (rst) begin
      sclk_sync  <= '0;
      din_sync   <= '0;
      syncb_sync <= '1;
      sclk_d     <= 1'b0;
      syncb_d    <= 1'b1;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      din_sync   <= {din_sync[SYNC_STAGES-2:0], DIN};
      syncb_sync <= {syncb_sync[SYNC_STAGES-2:0], SYNC_b};
      sclk_d     <= sclk_s;
      syncb_d    <= syncb_s;
    end
  end

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign din_s      = din_sync[SYNC_STAGES-1];
  assign syncb_s    = syncb_sync[SYNC_STAGES-1];
  assign sclk_fall  = sclk_d & ~sclk_s;
  assign syncb_rise = syncb_s & ~syncb_d;
  assign shift_next = (MSB_FIRST != 0) ? {shreg[14:0], din_s} : {din_s, shreg[15:1]};
  assign commit     = (state == SHIFT) && !syncb_rise && sclk_fall && (bit_cnt == 5'd15);

  // armed only once the whole SYNC_b chain has shown a genuine high after reset,
  // so a frame already in flight when reset drops is ignored
  always_ff @(posedge clkin) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      primed    <= 1'b0;
      armed     <= 1'b0;
      tdata     <= '0;
      tuser     <= '0;
      tctrl     <= 1'b0;
      tvalid    <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      primed    <= 1'b1;
      if (primed && (&syncb_sync) && syncb_d)
        armed <= 1'b1;
      if (tvalid && tready)
        tvalid <= 1'b0;
      case (state)
        IDLE: begin
          shreg   <= '0;
          bit_cnt <= '0;
          if (armed && !syncb_s)
            state <= SHIFT;
        end
        SHIFT: begin
          if (syncb_rise) begin
            if (bit_cnt != 5'd0)
              frame_err <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            state   <= IDLE;
          end else if (sclk_fall) begin
            shreg   <= shift_next;
            bit_cnt <= bit_cnt + 5'd1;
            if (commit) begin
              state <= DONE;
              if (!tvalid || tready) begin
                tdata  <= shift_next;
                tctrl  <= shift_next[15];
                tuser  <= shift_next[15] ? 3'd0 : shift_next[14:12];
                tvalid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (syncb_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AD5318_RX_REGFILE_EN
  logic [SYNC_STAGES-1:0] ldac_sync;
  logic [9:0]             in_reg  [8];
  logic [9:0]             dac_reg [8];

  // DAC registers copy the previous input-register contents, so a same-cycle commit lands one cycle later
  always_ff @(posedge clkin) begin
    if (rst) begin
      ldac_sync <= '1;
      for (int n = 0; n < 8; n++) begin
        in_reg[n]  <= '0;
        dac_reg[n] <= '0;
      end
    end else begin
      ldac_sync <= {ldac_sync[SYNC_STAGES-2:0], LDAC_b};
      if (commit && !shift_next[15])
        in_reg[shift_next[14:12]] <= shift_next[11:2];
      if (!ldac_sync[SYNC_STAGES-1])
        for (int n = 0; n < 8; n++)
          dac_reg[n] <= in_reg[n];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_dac
    assign dac_value[10*g+9:10*g] = dac_reg[g];
  end
`else
  logic unused_ldac;
  assign unused_ldac = LDAC_b;
`endif

endmodule

// File: tb/tb_ad5318_frame_rx.sv
// Bench for ad5318_frame_rx: table vectors, randomized frames against a word-level model, and
// hand-written overrun/reset sequences (plus register-file checks when AD5318_RX_REGFILE_EN is set).
`timescale 1ns/1ps
module tb_ad5318_frame_rx;

  logic        clkin = 1'b0;
  logic        rst, SCLK, DIN, SYNC_b, LDAC_b, tready;
  logic [15:0] tdata;
  logic [2:0]  tuser;
  logic        tctrl, tvalid, frame_err, overrun;
`ifdef AD5318_RX_REGFILE_EN
  logic [79:0] dac_value;
`endif

  always #5 clkin = ~clkin;

  ad5318_frame_rx #(.MSB_FIRST(1), .SYNC_STAGES(2)) dut (
    .clkin(clkin), .rst(rst), .SCLK(SCLK), .DIN(DIN), .SYNC_b(SYNC_b), .LDAC_b(LDAC_b),
    .tdata(tdata), .tuser(tuser), .tctrl(tctrl), .tvalid(tvalid), .tready(tready),
    .frame_err(frame_err), .overrun(overrun)
`ifdef AD5318_RX_REGFILE_EN
    , .dac_value(dac_value)
`endif
  );

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0, ovr_cnt = 0, valid_cycles = 0;
  logic [19:0] rx_q[$];
  logic        hold_prev = 1'b0;
  logic [19:0] hold_val;

  typedef struct {
    logic [31:0] data;
    int          nbits;
    int          exp_words;
    int          exp_ferr;
    logic [15:0] exp_tdata;
    logic [2:0]  exp_tuser;
    logic        exp_tctrl;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  // first serial bit is data[31]; SCLK high/low for 'half' clkin cycles each
  task automatic applyStimulus(input logic [31:0] data, input int nbits, input int half);
    SYNC_b = 1'b0;
    tick(3);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b1;
      DIN  = data[31-i];
      tick(half);
      SCLK = 1'b0;
      tick(half);
    end
    tick(2);
    SYNC_b = 1'b1;
    DIN    = 1'b0;
    tick(10);
  endtask

  function automatic logic [19:0] modelWord(input logic [15:0] w);
    logic       ctrl;
    logic [2:0] user;
    ctrl = (w >= 16'h8000);
    user = ctrl ? 3'd0 : 3'((w / 4096) % 8);
    return {ctrl, user, w};
  endfunction

  // stream monitor; also requires a stalled word to stay frozen
  always @(negedge clkin) begin
    if (!rst) begin
      if (tvalid && tready) rx_q.push_back({tctrl, tuser, tdata});
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (tvalid) valid_cycles++;
      if (hold_prev)
        checkOutput("hold_stable", 32'({tvalid, tctrl, tuser, tdata}), 32'({1'b1, hold_val}));
      hold_prev = tvalid && !tready;
      hold_val  = {tctrl, tuser, tdata};
    end else begin
      hold_prev = 1'b0;
    end
  end

  initial begin
    vec_t        vecs[6];
    logic [19:0] got, exp_w;
    logic [31:0] rdata;
    int          f0, v0, o0, nb, pick, half;

    vecs[0] = '{32'h3A5C_0000, 16, 1, 0, 16'h3A5C, 3'd3, 1'b0};
    vecs[1] = '{32'h8003_0000, 16, 1, 0, 16'h8003, 3'd0, 1'b1};
    vecs[2] = '{32'hFFFF_0000,  9, 0, 1, 16'h0000, 3'd0, 1'b0};
    vecs[3] = '{32'h1004_0000, 16, 1, 0, 16'h1004, 3'd1, 1'b0};
    vecs[4] = '{32'hC0DE_F000, 20, 1, 0, 16'hC0DE, 3'd0, 1'b1};
    vecs[5] = '{32'h0000_0000,  0, 0, 0, 16'h0000, 3'd0, 1'b0};

    rst = 1'b1; SCLK = 1'b0; DIN = 1'b0; SYNC_b = 1'b1; LDAC_b = 1'b1; tready = 1'b1;
    tick(3);
    checkOutput("reset_outputs", 32'({tvalid, tdata, tuser, tctrl, frame_err, overrun}), 32'h0);
    rst = 1'b0;
    tick(5);

    for (int i = 0; i < 6; i++) begin
      rx_q.delete();
      f0 = ferr_cnt;
      v0 = valid_cycles;
      applyStimulus(vecs[i].data, vecs[i].nbits, 4);
      checkOutput($sformatf("vec%0d_words", i), 32'(rx_q.size()), 32'(vecs[i].exp_words));
      checkOutput($sformatf("vec%0d_frame_err", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      if (vecs[i].exp_words == 1 && rx_q.size() == 1) begin
        got = rx_q.pop_front();
        checkOutput($sformatf("vec%0d_tdata", i), 32'(got[15:0]), 32'(vecs[i].exp_tdata));
        checkOutput($sformatf("vec%0d_tuser", i), 32'(got[18:16]), 32'(vecs[i].exp_tuser));
        checkOutput($sformatf("vec%0d_tctrl", i), 32'(got[19]), 32'(vecs[i].exp_tctrl));
        checkOutput($sformatf("vec%0d_valid_cycles", i), 32'(valid_cycles - v0), 32'd1);
      end
    end

    // randomized frames: lengths and SCLK rate vary, model works on whole words
    for (int k = 0; k < 24; k++) begin
      rdata = $urandom;
      pick  = $urandom_range(0, 9);
      nb    = (pick < 6) ? 16 : (pick < 8) ? $urandom_range(1, 15) : (pick == 8) ? $urandom_range(17, 20) : 0;
      half  = $urandom_range(2, 5);
      rx_q.delete();
      f0 = ferr_cnt;
      applyStimulus(rdata, nb, half);
      checkOutput($sformatf("rnd%0d_words", k), 32'(rx_q.size()), (nb >= 16) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rnd%0d_frame_err", k), 32'(ferr_cnt - f0), (nb >= 1 && nb <= 15) ? 32'd1 : 32'd0);
      if (nb >= 16 && rx_q.size() == 1) begin
        exp_w = modelWord(rdata[31:16]);
        got   = rx_q.pop_front();
        checkOutput($sformatf("rnd%0d_word", k), 32'(got), 32'(exp_w));
      end
    end

    // overrun: second frame dropped while first is stalled
    tready = 1'b0;
    rx_q.delete();
    o0 = ovr_cnt;
    applyStimulus(32'h1111_0000, 16, 4);
    applyStimulus(32'h2222_0000, 16, 4);
    checkOutput("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    checkOutput("ovr_tvalid", 32'(tvalid), 32'd1);
    checkOutput("ovr_tdata_kept", 32'(tdata), 32'h1111);
    tready = 1'b1;
    tick(1);
    checkOutput("ovr_accepted", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) checkOutput("ovr_accepted_word", 32'(rx_q.pop_front()), 32'(modelWord(16'h1111)));
    tick(3);
    checkOutput("ovr_tvalid_drop", 32'(tvalid), 32'd0);

    // reset mid-frame with a stalled word pending; the rest of that frame must be ignored
    tready = 1'b0;
    applyStimulus(32'h4321_0000, 16, 4);
    checkOutput("rstmid_pending", 32'(tvalid), 32'd1);
    SYNC_b = 1'b0;
    tick(3);
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b1; DIN = i[0]; tick(4);
      SCLK = 1'b0; tick(4);
    end
    rst = 1'b1;
    tick(1);
    checkOutput("rstmid_outputs", 32'({tvalid, tdata, tuser, tctrl, frame_err, overrun}), 32'h0);
    rst = 1'b0;
    f0 = ferr_cnt;
    v0 = valid_cycles;
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b1; DIN = 1'b1; tick(4);
      SCLK = 1'b0; tick(4);
    end
    tick(2);
    SYNC_b = 1'b1;
    tick(10);
    checkOutput("rstmid_no_word", 32'(valid_cycles - v0), 32'd0);
    checkOutput("rstmid_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    tready = 1'b1;
    rx_q.delete();
    applyStimulus(32'h7ABC_0000, 16, 4);
    checkOutput("rstmid_next_words", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() == 1) checkOutput("rstmid_next_word", 32'(rx_q.pop_front()), 32'(modelWord(16'h7ABC)));

`ifdef AD5318_RX_REGFILE_EN
    applyStimulus(32'h5AAC_0000, 16, 4);
    checkOutput("rf_ch5_before_ldac", 32'(dac_value[59:50]), 32'h0);
    LDAC_b = 1'b0;
    tick(5);
    LDAC_b = 1'b1;
    tick(3);
    checkOutput("rf_ch5_after_ldac", 32'(dac_value[59:50]), 32'h2AB);
    checkOutput("rf_ch0_untouched", 32'(dac_value[9:0]), 32'h0);
    SYNC_b = 1'b0;
    tick(3);
    SCLK = 1'b1; DIN = 1'b1; tick(4);
    SCLK = 1'b0; tick(4);
    rst = 1'b1;
    tick(1);
    checkOutput("rf_reset_dac", (dac_value == 80'd0) ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b0;
    SYNC_b = 1'b1;
    tick(10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
